// File: rtl/lpddr2_bridge.sv
// lpddr2_bridge: single-word CPU load/store bridge onto an LPDDR2 controller Avalon port.
// Optional controller-wait watchdog is built in when LPDDR2_TIMEOUT_EN is defined.
module lpddr2_bridge #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [26:0] address,
   input  logic [31:0] write_data,
   input  logic        read_req,
   input  logic        write_req,
   output logic [31:0] read_data,
   output logic        done,
   output logic        busy,
   input  logic        local_init_done,
   input  logic        avl_ready,
   output logic [26:0] avl_addr,
   output logic [31:0] avl_wdata,
   output logic [3:0]  avl_be,
   output logic [2:0]  avl_size,
   output logic        avl_burstbegin,
   output logic        avl_read_req,
   output logic        avl_write_req,
   input  logic [31:0] avl_rdata,
   input  logic        avl_rdata_valid,
   output logic        timeout_err
);

   typedef enum logic [2:0] {INIT, IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE} state_t;

   state_t      state_reg;
   logic        armed_reg;
   logic        busy_reg;
   logic        done_reg;
   logic        burst_reg;
   logic        rd_strobe_reg;
   logic        wr_strobe_reg;
   logic [26:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [31:0] rdata_reg;
   logic        tmo_hit;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("lpddr2_bridge: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef LPDDR2_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt_reg;
   logic          timeout_err_reg;

   // Fires only on the last allowed cycle when the controller has still not responded.
   assign tmo_hit = (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) &&
                    (((state_reg == RD_ISSUE || state_reg == WR_ISSUE) && !avl_ready) ||
                     (state_reg == RD_WAIT && !avl_rdata_valid));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_reg     <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         if (state_reg == RD_ISSUE || state_reg == RD_WAIT || state_reg == WR_ISSUE)
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
         else
            tmo_cnt_reg <= '0;
         if (tmo_hit)
            timeout_err_reg <= 1'b1;
      end
   end

   assign timeout_err = timeout_err_reg;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= INIT;
         armed_reg     <= 1'b0;
         busy_reg      <= 1'b1;
         done_reg      <= 1'b0;
         burst_reg     <= 1'b0;
         rd_strobe_reg <= 1'b0;
         wr_strobe_reg <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         rdata_reg     <= '0;
      end else begin
         done_reg  <= 1'b0;
         burst_reg <= 1'b0;
         case (state_reg)
            INIT: begin
               // Requests held off during calibration are served once it completes.
               if (local_init_done) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  armed_reg <= 1'b1;
               end
            end
            IDLE: begin
               if (!read_req && !write_req) begin
                  armed_reg <= 1'b1;
               end else if (armed_reg) begin
                  armed_reg <= 1'b0;
                  busy_reg  <= 1'b1;
                  burst_reg <= 1'b1;
                  addr_reg  <= address;
                  wdata_reg <= write_data;
                  if (write_req) begin
                     state_reg     <= WR_ISSUE;
                     wr_strobe_reg <= 1'b1;
                  end else begin
                     state_reg     <= RD_ISSUE;
                     rd_strobe_reg <= 1'b1;
                  end
               end
            end
            RD_ISSUE: begin
               if (avl_ready) begin
                  rd_strobe_reg <= 1'b0;
                  state_reg     <= RD_WAIT;
               end else if (tmo_hit) begin
                  rd_strobe_reg <= 1'b0;
                  rdata_reg     <= 32'hDEADBEEF;
                  done_reg      <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            RD_WAIT: begin
               if (avl_rdata_valid) begin
                  rdata_reg <= avl_rdata;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else if (tmo_hit) begin
                  rdata_reg <= 32'hDEADBEEF;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            WR_ISSUE: begin
               if (avl_ready || tmo_hit) begin
                  wr_strobe_reg <= 1'b0;
                  done_reg      <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= INIT;
         endcase
      end
   end

   assign read_data      = rdata_reg;
   assign done           = done_reg;
   assign busy           = busy_reg;
   assign avl_addr       = addr_reg;
   assign avl_wdata      = wdata_reg;
   assign avl_be         = 4'hF;
   assign avl_size       = 3'd1;
   assign avl_burstbegin = burst_reg;
   assign avl_read_req   = rd_strobe_reg;
   assign avl_write_req  = wr_strobe_reg;

endmodule

// File: doc/lpddr2_bridge.md
LPDDR2_BRIDGE -- requirements
Module: lpddr2_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum cycles a transaction may wait at the controller.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-004 SHALL have port address, input, 27: word address from the CPU memory stage.
REQ-005 SHALL have port write_data, input, 32: store data.
REQ-006 SHALL have port read_req, input, 1: read request level.
REQ-007 SHALL have port write_req, input, 1: write request level.
REQ-008 SHALL have port read_data, output, 32: registered load result.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port local_init_done, input, 1: controller calibration complete.
REQ-012 SHALL have port avl_ready, input, 1: controller accepts the command this cycle.
REQ-013 SHALL have ports avl_addr (output, 27), avl_wdata (output, 32), avl_be (output, 4), avl_size (output, 3) and avl_burstbegin (output, 1): Avalon command fields.
REQ-014 SHALL have ports avl_read_req (output, 1) and avl_write_req (output, 1): Avalon command strobes.
REQ-015 SHALL have ports avl_rdata (input, 32) and avl_rdata_valid (input, 1): Avalon read return.
REQ-016 SHALL have port timeout_err, output, 1: sticky timeout flag.

Function
REQ-017 SHALL implement the states INIT, IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE and DONE.
REQ-018 SHALL move from INIT to IDLE on the first cycle local_init_done is high; requests arriving in INIT are held off.
REQ-019 SHALL keep an armed flag that is cleared when a transaction starts and set in any IDLE cycle where read_req and write_req are both low.
REQ-020 SHALL, in IDLE with armed high, go to WR_ISSUE if write_req is high, else to RD_ISSUE if read_req is high.
REQ-021 SHALL give write priority when read_req and write_req are high together; the read is not performed.
REQ-022 SHALL latch address and write_data on transaction start and drive avl_addr and avl_wdata from the latches.
REQ-023 SHALL drive avl_size=3'd1 and avl_be=4'hF at all times.
REQ-024 SHALL, in RD_ISSUE or WR_ISSUE, hold the matching strobe high until a cycle with avl_ready high.
REQ-025 SHALL assert avl_burstbegin only in the first cycle of each ISSUE state.
REQ-026 SHALL go from RD_ISSUE to RD_WAIT, and from WR_ISSUE to DONE, on the cycle avl_ready is high.
REQ-027 SHALL, in RD_WAIT, capture avl_rdata into read_data on avl_rdata_valid and go to DONE.
REQ-028 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-029 SHALL hold read_data stable between reads; writes do not alter it.
REQ-030 SHALL give a read latency of 2 cycles plus avl_ready wait plus return latency, measured from start to done.
REQ-031 SHALL ignore avl_rdata_valid outside RD_WAIT.

Reset
REQ-032 SHALL, on rst, asynchronously enter INIT with armed=0, read_data=0, timeout_err=0 and all avl strobes, burstbegin and done at 0.
REQ-033 SHALL abandon any in-flight transaction on rst without a done pulse; any late avl_rdata_valid is then ignored.

Configuration
REQ-034 SHALL, with LPDDR2_TIMEOUT_EN defined, count cycles spent in the ISSUE and WAIT states, clearing the count on start.
REQ-035 SHALL, with LPDDR2_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES, set timeout_err, load read_data=32'hDEADBEEF for reads, drop strobes and go to DONE.
REQ-036 SHALL, without LPDDR2_TIMEOUT_EN, wait indefinitely, tie timeout_err to 0 and omit the counter.

Verification
REQ-037 SHALL cover a read: read_req=1, address=27'h10, avl_ready=1, valid after 5 cycles with rdata=32'hCAFEF00D -> read_data=32'hCAFEF00D, one done pulse, avl_burstbegin high exactly once.
REQ-038 SHALL cover write backpressure: write_req=1, avl_ready low 3 cycles -> avl_write_req high 4 cycles, done after acceptance, read_data unchanged.
REQ-039 SHALL cover simultaneous requests: read_req=write_req=1 -> only avl_write_req issued; holding both high starts no second transaction until both drop.
REQ-040 SHALL cover a timeout (macro on, TIMEOUT_CYCLES=8): read with no rdata_valid -> done after 8 wait cycles, read_data=32'hDEADBEEF, timeout_err stays 1.
REQ-041 SHALL cover reset mid-read: rst in RD_WAIT, then valid pulse -> INIT, no done, read_data=0.
REQ-042 SHALL cover the init gate: local_init_done=0 with read_req=1 -> busy=1, no strobes; local_init_done=1 -> read proceeds.
